// File: rtl/sequential_divider_pkg.sv
// Shared ALU definitions: divider FSM states and the default operand width.
package sequential_divider_pkg;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/sequential_divider_if.sv
// Request/result bundle for the sequential divider; master drives operands, slave returns results.
interface sequential_divider_if
  import sequential_divider_pkg::*;
#(
  parameter int l = DEF_WIDTH
) ();
  logic         Start;
  logic [l-1:0] X;
  logic [l-1:0] Y;
  logic         Busy;
  logic         Done;
  logic [l-1:0] Quotient;
  logic [l-1:0] Remainder;
  logic         DivByZero;

  modport master (
    output Start, X, Y,
    input  Busy, Done, Quotient, Remainder, DivByZero
  );

  modport slave (
    input  Start, X, Y,
    output Busy, Done, Quotient, Remainder, DivByZero
  );
endinterface

// File: rtl/sequential_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
  import sequential_divider_pkg::*;
#(
  parameter int l = DEF_WIDTH
) (
  input  logic [l:0]   rem_in,
  input  logic         dividend_bit,
  input  logic [l-1:0] divisor,
  output logic [l:0]   rem_out,
  output logic         q_bit
);
  logic [l+1:0] shifted;
  logic [l:0]   diff;

  // The compare uses the full shifted value so no bit is dropped before the decision.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    q_bit   = (shifted >= {2'b00, divisor});
    diff    = shifted[l:0] - {1'b0, divisor};
    rem_out = q_bit ? diff : shifted[l:0];
  end
endmodule

// File: rtl/sequential_divider.sv
// Unsigned l-bit restoring divider, one quotient bit per clock, l cycles busy per request.
// Divide-by-zero completes on the accepting edge; results hold until the next completion.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int l = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  sequential_divider_if.slave bus
);
  localparam int CW = $clog2(l) + 1;

  div_state_t   state, state_nxt;
  logic [l-1:0] dividend;
  logic [l-1:0] divisor;
  logic [l:0]   rem;
  logic [CW-1:0] count;
  logic [l-1:0] quo_q;
  logic [l-1:0] rem_q;
  logic         dbz_q;

  logic         accept;
  logic         last_step;
  logic         step_q_bit;
  logic [l:0]   rem_nxt;

  div_step #(.l(l)) u_step (
    .rem_in       (rem),
    .dividend_bit (dividend[l-1]),
    .divisor      (divisor),
    .rem_out      (rem_nxt),
    .q_bit        (step_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          state_nxt = (bus.Y == '0) ? DONE : RUN;
        end else if (state == DONE) begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (count == CW'(l - 1)) begin
          last_step = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The dividend register doubles as the quotient accumulator: bits leave at the top, quotient bits enter at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      count    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      dividend <= bus.X;
      divisor  <= bus.Y;
      rem      <= '0;
      count    <= '0;
      if (bus.Y == '0) begin
        quo_q <= '1;
        rem_q <= bus.X;
        dbz_q <= 1'b1;
      end
    end else if (state == RUN) begin
      dividend <= {dividend[l-2:0], step_q_bit};
      rem      <= rem_nxt;
      count    <= count + 1'b1;
      if (last_step) begin
        quo_q <= {dividend[l-2:0], step_q_bit};
        rem_q <= rem_nxt[l-1:0];
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.Busy      = (state == RUN);
  assign bus.Done      = (state == DONE);
  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_sequential_divider.sv
// Directed and random checks of the sequential divider against a queue of bench-computed results.
module tb_sequential_divider;
  import sequential_divider_pkg::*;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  sequential_divider_if #(.l(16)) bus ();

  sequential_divider #(.l(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one accepting edge and pushes the expected result.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    if (y == 16'd0) begin
      e.q = 16'hFFFF; e.r = x; e.dbz = 1'b1;
    end else begin
      e.q = x / y; e.r = x % y; e.dbz = 1'b0;
    end
    sb.push_back(e);
    bus.Start = 1'b1;
    bus.X = x;
    bus.Y = y;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy);
    lat = 0;
    busy = 0;
    while (!bus.Done && lat < 200) begin
      if (bus.Busy) busy++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    check({tag, "_sb_avail"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_done"}, 32'(bus.Done), 32'd1);
      check({tag, "_q"}, 32'(bus.Quotient), 32'(e.q));
      check({tag, "_r"}, 32'(bus.Remainder), 32'(e.r));
      check({tag, "_dbz"}, 32'(bus.DivByZero), 32'(e.dbz));
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input int exp_lat);
    int lat, busy;
    start_op(x, y);
    wait_done(lat, busy);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_lat));
    check({tag, "_busy_in_done"}, 32'(bus.Busy), 32'd0);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(bus.Done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int lat, busy, done_seen;
    logic [15:0] rx, ry;

    bus.Start = 1'b0;
    bus.X = '0;
    bus.Y = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_q", 32'(bus.Quotient), 32'd0);
    check("rst_r", 32'(bus.Remainder), 32'd0);
    check("rst_dbz", 32'(bus.DivByZero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("d100_7", 16'd100, 16'd7, 16);
    run_op("dffff_1", 16'hFFFF, 16'd1, 16);
    run_op("d5_9", 16'd5, 16'd9, 16);
    run_op("d1234_0", 16'h1234, 16'd0, 0);
    run_op("d0_3", 16'd0, 16'd3, 16);
    run_op("d7_0", 16'd7, 16'd0, 0);
    run_op("d65535_65535", 16'hFFFF, 16'hFFFF, 16);

    // Start re-pulsed mid-RUN must be ignored
    start_op(16'd50, 16'd5);
    repeat (5) @(negedge clk);
    check("ign_busy_mid", 32'(bus.Busy), 32'd1);
    bus.Start = 1'b1;
    bus.X = 16'd9;
    bus.Y = 16'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_done(lat, busy);
    check("ign_lat", 32'(lat + 6), 32'd16);
    check_result("ign");
    @(negedge clk);
    check("ign_done_one_cycle", 32'(bus.Done), 32'd0);

    // Reset in the middle of RUN abandons the operation
    bus.Start = 1'b1;
    bus.X = 16'd200;
    bus.Y = 16'd3;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (7) @(negedge clk);
    check("rrun_busy_before", 32'(bus.Busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rrun_busy", 32'(bus.Busy), 32'd0);
    check("rrun_done", 32'(bus.Done), 32'd0);
    check("rrun_q", 32'(bus.Quotient), 32'd0);
    check("rrun_r", 32'(bus.Remainder), 32'd0);
    check("rrun_dbz", 32'(bus.DivByZero), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.Done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) done_seen++;
    end
    check("rrun_no_done", 32'(done_seen), 32'd0);
    run_op("after_rst_9_2", 16'd9, 16'd2, 16);

    // Back-to-back: Start held through the DONE cycle
    start_op(16'd1000, 16'd10);
    wait_done(lat, busy);
    check("b2b_first_lat", 32'(lat), 32'd16);
    check_result("b2b_first");
    start_op(16'd21, 16'd4);
    check("b2b_no_idle_gap", 32'(bus.Busy), 32'd1);
    wait_done(lat, busy);
    check("b2b_second_lat", 32'(lat), 32'd16);
    check_result("b2b_second");
    @(negedge clk);
    check("b2b_done_one_cycle", 32'(bus.Done), 32'd0);

    // A few random operand pairs
    for (int i = 0; i < 4; i++) begin
      rx = 16'($urandom_range(0, 65535));
      ry = 16'($urandom_range(1, 400));
      run_op("rand", rx, ry, 16);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
